systolic_result_drain: RTL and testbench
========================================

Name: systolic_result_drain

Overview:
- Reads the N x N accumulator results out of a SystolicArray once a matrix multiply has finished.
- Sequences select_accumulator one PE at a time in row-major order and waits for each PE to reach IDLE and raise accumulator_valid.
- Captures each PE's east-side value and streams it out over a valid/ready interface tagged with row/column.
- Sits between the array and the result buffer/host; it is the consumer of the array's accumulator-readout protocol.

Parameters:
- N, 3, array dimension (rows = cols).
- DATA_WIDTH, 32, accumulator/result width (FP32 bit pattern, passed through untouched).
- TIMEOUT, 255, max cycles to wait for accumulator_valid after select; 1..65535.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse; begin draining all N*N PEs.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse after the last result handshake.
- pe_idle_i  in  N*N  PE[r][c] FSM in IDLE; bit index r*N+c.
- accumulator_valid_i  in  N*N  array accumulator_valid_o, flattened r*N+c.
- pe_east_i  in  N*N*DATA_WIDTH  east output of PE[r][c]; slice [(r*N+c)*DATA_WIDTH +: DATA_WIDTH]. For c=N-1 this is east_o[r].
- select_accumulator_o  out  N*N  to array select_accumulator_i; at most one bit high.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  downstream accepts result.
- out_data_o  out  DATA_WIDTH  captured accumulator value.
- out_row_o  out  $clog2(N)  row of the result.
- out_col_o  out  $clog2(N)  column of the result.
- out_timeout_o  out  1  qualifies out_data_o: the PE timed out; data forced to 0.
- error_o  out  1  sticky; set on any timeout, cleared by the next accepted start.

Behaviour:
- Reset (async, immediate): state IDLE, all outputs 0, index 0, timer 0.
- Index: single counter idx 0..N*N-1. out_row_o = idx/N and out_col_o = idx%N, both registered.
- FSM, one state per clock:
  - IDLE: busy_o=0. start_i=1 -> WAIT_IDLE with idx=0 and error_o cleared. start_i outside IDLE is ignored.
  - WAIT_IDLE: select all-zero. pe_idle_i[idx]=1 -> SELECT. Waits indefinitely.
  - SELECT: select_accumulator_o[idx] goes high on this edge (registered). Timer=0. -> WAIT_VALID.
  - WAIT_VALID: select held high; timer increments each cycle.
    - accumulator_valid_i[idx]=1 sampled: capture the pe_east_i slice into out_data_o, out_timeout_o=0, deassert select on the same edge -> PUSH.
    - Else if timer==TIMEOUT-1: out_data_o=0, out_timeout_o=1, error_o=1, deassert select -> PUSH.
    - Valid takes priority over timeout in the same cycle.
  - PUSH: out_valid_o=1. out_data_o, out_row_o, out_col_o and out_timeout_o stay stable until the handshake (out_valid_o & out_ready_i).
    - On handshake with idx==N*N-1: -> DONE.
    - On handshake otherwise: idx++, -> WAIT_IDLE.
  - DONE: done_o=1 for one cycle, busy_o=0 -> IDLE.
- Minimum per-PE latency, with idle and ready already high and valid arriving one cycle after select: WAIT_IDLE 1 + SELECT 1 + WAIT_VALID 1 + PUSH 1 = 4 cycles, giving 4*N*N+1 cycles to done_o.
- Select is asserted for at least 1 cycle and is never asserted outside SELECT/WAIT_VALID. No two select bits are ever high together.
- accumulator_valid_i on bits other than idx is ignored.
- Reset mid-drain drops select and out_valid_o asynchronously. No partial result is emitted after reset release.

Test Plan:
- N=3, array loaded with A*I where A=1..9: start -> 9 results in order (0,0)..(2,2), data 0x3F800000..0x41100000, done_o after the 9th handshake, error_o=0.
- Random 3x3 product: results 0x41700000, 0x41D00000, 0x42140000, 0x42340000, 0x428E0000, 0x42C20000, 0x42960000, 0x42E80000, 0x431D0000 in row-major order with correct row/col tags.
- out_ready_i held low for 7 cycles on result (1,1) -> out_valid_o stays high with data 0x428E0000 stable. select stays 0 and idx stays 4 until ready.
- pe_idle_i[5] held low for 20 cycles -> select_accumulator_o stays 0 for those cycles, then bit 5 rises one cycle after idle.
- TIMEOUT=8, accumulator_valid_i[2] never asserted -> select bit 2 high for 8 cycles, result (0,2) emitted with data 0 and out_timeout_o=1, error_o=1, drain continues; the next start clears error_o.
- rst_i pulsed while in WAIT_VALID on idx 3 -> select and out_valid_o drop immediately. A new start after reset drains from (0,0). A start_i pulse during busy is ignored (no restart, idx unchanged).

Source files
------------

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: reads the N x N accumulator results out of a systolic array one PE at a time
// in row-major order and streams each value out over a valid/ready port tagged with row/column.
`default_nettype none

module systolic_result_drain #(
    parameter int N          = 3,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    input  logic [N*N-1:0]               pe_idle_i,
    input  logic [N*N-1:0]               accumulator_valid_i,
    input  logic [N*N*DATA_WIDTH-1:0]    pe_east_i,
    output logic [N*N-1:0]               select_accumulator_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_WIDTH-1:0]        out_data_o,
    output logic [$clog2(N)-1:0]         out_row_o,
    output logic [$clog2(N)-1:0]         out_col_o,
    output logic                         out_timeout_o,
    output logic                         error_o
);

    localparam int NN = N * N;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam int RW = $clog2(N);
    localparam logic [IW-1:0] c_LAST_IDX = IW'(NN - 1);
    localparam logic [RW-1:0] c_LAST_COL = RW'(N - 1);
    localparam logic [15:0]   c_TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_IDLE  = 3'd1,
        S_SELECT     = 3'd2,
        S_WAIT_VALID = 3'd3,
        S_PUSH       = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [IW-1:0]         r_idx;
    logic [RW-1:0]         r_row;
    logic [RW-1:0]         r_col;
    logic [15:0]           r_timer;
    logic [NN-1:0]         r_sel;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_tmo;
    logic                  r_error;

    logic [DATA_WIDTH-1:0] w_east [NN];
    logic [NN-1:0]         w_onehot;
    logic                  w_idle_cur;
    logic                  w_valid_cur;
    logic                  w_handshake;
    logic                  w_timeout;

    for (genvar g = 0; g < NN; g++) begin : g_east
        assign w_east[g] = pe_east_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_onehot    = NN'(1) << r_idx;
    assign w_idle_cur  = pe_idle_i[r_idx];
    assign w_valid_cur = accumulator_valid_i[r_idx];
    assign w_handshake = (r_state == S_PUSH) && out_ready_i;
    // Timer is 0 during SELECT, so select stays high for exactly TIMEOUT cycles on a timeout.
    assign w_timeout   = (r_state == S_WAIT_VALID) && !w_valid_cur && (r_timer >= c_TMO_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (start_i)     w_next = S_WAIT_IDLE;
            S_WAIT_IDLE:  if (w_idle_cur)  w_next = S_SELECT;
            S_SELECT:                      w_next = S_WAIT_VALID;
            S_WAIT_VALID: if (w_valid_cur || w_timeout) w_next = S_PUSH;
            S_PUSH:       if (w_handshake) w_next = (r_idx == c_LAST_IDX) ? S_DONE : S_WAIT_IDLE;
            S_DONE:                        w_next = S_IDLE;
            default:                       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_timer <= '0;
            r_sel   <= '0;
            r_data  <= '0;
            r_tmo   <= 1'b0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_idx   <= '0;
                    r_row   <= '0;
                    r_col   <= '0;
                    r_error <= 1'b0;
                end
                S_WAIT_IDLE: if (w_idle_cur) begin
                    r_sel   <= w_onehot;
                    r_timer <= '0;
                end
                S_SELECT: r_timer <= r_timer + 16'd1;
                S_WAIT_VALID: begin
                    r_timer <= r_timer + 16'd1;
                    if (w_valid_cur) begin
                        r_data <= w_east[r_idx];
                        r_tmo  <= 1'b0;
                        r_sel  <= '0;
                    end else if (w_timeout) begin
                        r_data  <= '0;
                        r_tmo   <= 1'b1;
                        r_error <= 1'b1;
                        r_sel   <= '0;
                    end
                end
                S_PUSH: if (w_handshake && (r_idx != c_LAST_IDX)) begin
                    r_idx <= r_idx + IW'(1);
                    if (r_col == c_LAST_COL) begin
                        r_col <= '0;
                        r_row <= r_row + RW'(1);
                    end else begin
                        r_col <= r_col + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o               = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done_o               = (r_state == S_DONE);
    assign out_valid_o          = (r_state == S_PUSH);
    assign select_accumulator_o = r_sel;
    assign out_data_o           = r_data;
    assign out_row_o            = r_row;
    assign out_col_o            = r_col;
    assign out_timeout_o        = r_tmo;
    assign error_o              = r_error;

endmodule

`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain (N=3, TIMEOUT=8) with a simple PE-array responder.
`default_nettype none

module tb_systolic_result_drain;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic [8:0]  pe_idle_i;
    logic [8:0]  accumulator_valid_i;
    logic [287:0] pe_east_i;
    logic [8:0]  select_accumulator_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [1:0]  out_row_o;
    logic [1:0]  out_col_o;
    logic        out_timeout_o;
    logic        error_o;

    logic [8:0]  valid_mask;
    logic [31:0] dA [9];
    logic [31:0] dB [9];
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    systolic_result_drain #(.N(3), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .pe_idle_i(pe_idle_i), .accumulator_valid_i(accumulator_valid_i), .pe_east_i(pe_east_i),
        .select_accumulator_o(select_accumulator_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_row_o(out_row_o),
        .out_col_o(out_col_o), .out_timeout_o(out_timeout_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    // PE model: raises accumulator_valid one cycle after its select is seen.
    always @(posedge clk) accumulator_valid_i <= select_accumulator_o & valid_mask;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_east(input logic [31:0] d [9]);
        for (int k = 0; k < 9; k++) pe_east_i[k*32 +: 32] = d[k];
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic get_result(input int k, input logic [31:0] d, input logic tmo);
        int n = 0;
        while (!out_valid_o && n < 60) begin
            tick();
            n++;
        end
        check("result_valid", 64'(out_valid_o), 64'd1);
        check("result_data", 64'(out_data_o), 64'(d));
        check("result_row", 64'(out_row_o), 64'(k / 3));
        check("result_col", 64'(out_col_o), 64'(k % 3));
        check("result_tmo", 64'(out_timeout_o), 64'(tmo));
        tick();
    endtask

    initial begin
        int t0;
        int cnt;
        logic [8:0] seen;
        dA = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
        dB = '{32'h41700000, 32'h41D00000, 32'h42140000, 32'h42340000, 32'h428E0000,
               32'h42C20000, 32'h42960000, 32'h42E80000, 32'h431D0000};
        rst_i = 1'b1; start_i = 1'b0; out_ready_i = 1'b1;
        pe_idle_i = 9'h1FF; valid_mask = 9'h1FF; pe_east_i = '0;
        load_east(dA);
        tick(); tick();
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_select", 64'(select_accumulator_o), 64'd0);
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_error", 64'(error_o), 64'd0);
        check("rst_data", 64'(out_data_o), 64'd0);
        rst_i = 1'b0;
        tick();

        // Identity-scaled array: 1.0 .. 9.0
        pulse_start();
        check("busy_after_start", 64'(busy_o), 64'd1);
        for (int k = 0; k < 9; k++) get_result(k, dA[k], 1'b0);
        check("done_pulse", 64'(done_o), 64'd1);
        check("done_busy", 64'(busy_o), 64'd0);
        check("done_error", 64'(error_o), 64'd0);
        tick();
        check("done_one_cycle", 64'(done_o), 64'd0);

        // Random product, minimum-latency timing to done
        load_east(dB);
        pulse_start();
        t0 = cyc;
        for (int k = 0; k < 9; k++) get_result(k, dB[k], 1'b0);
        check("latency_done", 64'(done_o), 64'd1);
        check("latency_cycles", 64'(cyc - t0), 64'd36);
        tick();

        // Backpressure on (1,1), then PE 5 held non-idle
        pulse_start();
        for (int k = 0; k < 4; k++) get_result(k, dB[k], 1'b0);
        out_ready_i = 1'b0;
        cnt = 0;
        while (!out_valid_o && cnt < 60) begin tick(); cnt++; end
        check("stall_row", 64'(out_row_o), 64'd1);
        check("stall_col", 64'(out_col_o), 64'd1);
        for (int i = 0; i < 7; i++) begin
            check("stall_valid", 64'(out_valid_o), 64'd1);
            check("stall_data", 64'(out_data_o), 64'h428E0000);
            check("stall_select", 64'(select_accumulator_o), 64'd0);
            tick();
        end
        check("stall_idx", 64'({out_row_o, out_col_o}), 64'(4'b0101));
        pe_idle_i[5] = 1'b0;
        out_ready_i = 1'b1;
        get_result(4, dB[4], 1'b0);
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            seen |= select_accumulator_o;
            tick();
        end
        check("idle_wait_select", 64'(seen), 64'd0);
        pe_idle_i[5] = 1'b1;
        tick();
        check("idle_select_rise", 64'(select_accumulator_o), 64'h020);
        for (int k = 5; k < 9; k++) get_result(k, dB[k], 1'b0);
        check("stall_done", 64'(done_o), 64'd1);
        tick();

        // Timeout on PE 2
        valid_mask = 9'h1FB;
        pulse_start();
        get_result(0, dB[0], 1'b0);
        get_result(1, dB[1], 1'b0);
        cnt = 0;
        while (select_accumulator_o == 9'd0 && cnt < 60) begin tick(); cnt++; end
        cnt = 0;
        while (select_accumulator_o == 9'h004 && cnt < 50) begin tick(); cnt++; end
        check("tmo_select_cycles", 64'(cnt), 64'd8);
        check("tmo_valid", 64'(out_valid_o), 64'd1);
        check("tmo_data", 64'(out_data_o), 64'd0);
        check("tmo_flag", 64'(out_timeout_o), 64'd1);
        check("tmo_error", 64'(error_o), 64'd1);
        check("tmo_col", 64'(out_col_o), 64'd2);
        tick();
        valid_mask = 9'h1FF;
        for (int k = 3; k < 9; k++) get_result(k, dB[k], 1'b0);
        check("tmo_done", 64'(done_o), 64'd1);
        check("tmo_error_sticky", 64'(error_o), 64'd1);
        tick();
        pulse_start();
        check("error_cleared", 64'(error_o), 64'd0);

        // Start ignored while busy, then reset in WAIT_VALID on idx 3
        get_result(0, dB[0], 1'b0);
        pulse_start();
        get_result(1, dB[1], 1'b0);
        get_result(2, dB[2], 1'b0);
        valid_mask = 9'h1F7;
        cnt = 0;
        while (select_accumulator_o == 9'd0 && cnt < 60) begin tick(); cnt++; end
        check("rst_case_select", 64'(select_accumulator_o), 64'h008);
        tick();
        check("rst_case_hold", 64'(select_accumulator_o), 64'h008);
        rst_i = 1'b1;
        #1;
        check("async_select", 64'(select_accumulator_o), 64'd0);
        check("async_valid", 64'(out_valid_o), 64'd0);
        check("async_busy", 64'(busy_o), 64'd0);
        tick();
        rst_i = 1'b0;
        valid_mask = 9'h1FF;
        seen = '0;
        for (int i = 0; i < 5; i++) begin
            seen[0] = seen[0] | out_valid_o;
            tick();
        end
        check("no_partial_result", 64'(seen), 64'd0);
        pulse_start();
        for (int k = 0; k < 9; k++) get_result(k, dB[k], 1'b0);
        check("restart_done", 64'(done_o), 64'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
